// File: rtl/cop_wb_queue.sv
// Writeback queue between the coprocessor Exec stage and the core register-file port.
// In-order buffer with RAW hazard detection and an exception block held until flush.
module cop_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          I_VALID,
  output logic          I_READY,
  input  logic [31:0]   I_PC,
  input  logic          I_REG_W_EN,
  input  logic [4:0]    I_REG_W_RD,
  input  logic [31:0]   I_REG_W_DATA,
  input  logic          I_EXC_EN,
  input  logic [3:0]    I_EXC_CODE,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic [31:0]   O_PC,
  output logic          O_REG_W_EN,
  output logic [4:0]    O_REG_W_RD,
  output logic [31:0]   O_REG_W_DATA,
  output logic          O_EXC_EN,
  output logic [3:0]    O_EXC_CODE,
  input  logic [4:0]    H_RS1,
  input  logic [4:0]    H_RS2,
  output logic          H_STALL,
  output logic [AW:0]   COUNT,
  output logic          EXC_PENDING,
  output logic          OVERFLOW
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0] pc_mem   [DEPTH];
  logic        wen_mem  [DEPTH];
  logic [4:0]  rd_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic        exc_mem  [DEPTH];
  logic [3:0]  code_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          exc_pending_reg;
  logic          overflow_reg;

  logic             not_empty;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit;

  assign not_empty = (count_reg != '0);
  assign I_READY   = (count_reg != FULL_CNT);
  assign push      = I_VALID && I_READY && !exc_pending_reg && !FLUSH;
  assign pop       = not_empty && O_READY && !FLUSH;

  assign O_VALID     = not_empty;
  assign COUNT       = count_reg;
  assign EXC_PENDING = exc_pending_reg;
  assign OVERFLOW    = overflow_reg;

  // Entry storage has no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= I_PC;
      wen_mem[wr_ptr_reg]  <= I_REG_W_EN && (I_REG_W_RD != 5'd0);
      rd_mem[wr_ptr_reg]   <= I_REG_W_RD;
      data_mem[wr_ptr_reg] <= I_REG_W_DATA;
      exc_mem[wr_ptr_reg]  <= I_EXC_EN;
      code_mem[wr_ptr_reg] <= I_EXC_CODE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      exc_pending_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      if (I_VALID && !I_READY && !exc_pending_reg)
        overflow_reg <= 1'b1;
      if (FLUSH) begin
        wr_ptr_reg      <= '0;
        rd_ptr_reg      <= '0;
        count_reg       <= '0;
        exc_pending_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (push && I_EXC_EN) exc_pending_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    O_PC         = '0;
    O_REG_W_EN   = 1'b0;
    O_REG_W_RD   = '0;
    O_REG_W_DATA = '0;
    O_EXC_EN     = 1'b0;
    O_EXC_CODE   = '0;
    if (not_empty) begin
      O_PC         = pc_mem[rd_ptr_reg];
      O_REG_W_EN   = wen_mem[rd_ptr_reg];
      O_REG_W_RD   = rd_mem[rd_ptr_reg];
      O_REG_W_DATA = data_mem[rd_ptr_reg];
      O_EXC_EN     = exc_mem[rd_ptr_reg];
      O_EXC_CODE   = code_mem[rd_ptr_reg];
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [AW-1:0] offs;
      logic          live;
      logic          match1;
      logic          match2;
      assign offs    = IDX - rd_ptr_reg;
      assign live    = ({1'b0, offs} < count_reg);
      assign match1  = (H_RS1 != 5'd0) && (rd_mem[gi] == H_RS1);
      assign match2  = (H_RS2 != 5'd0) && (rd_mem[gi] == H_RS2);
      assign hit[gi] = live && wen_mem[gi] && (match1 || match2);
    end
  endgenerate

  assign H_STALL = |hit;

endmodule

// File: tb/tb_cop_wb_queue.sv
// Directed bench for cop_wb_queue: a reference queue holds expected entries and
// every cycle checks occupancy, flags, hazard output and the head entry.
module tb_cop_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, I_VALID, I_READY;
  logic [31:0] I_PC, I_REG_W_DATA;
  logic        I_REG_W_EN, I_EXC_EN;
  logic [4:0]  I_REG_W_RD;
  logic [3:0]  I_EXC_CODE;
  logic        O_VALID, O_READY;
  logic [31:0] O_PC, O_REG_W_DATA;
  logic        O_REG_W_EN, O_EXC_EN;
  logic [4:0]  O_REG_W_RD;
  logic [3:0]  O_EXC_CODE;
  logic [4:0]  H_RS1, H_RS2;
  logic        H_STALL;
  logic [AW:0] COUNT;
  logic        EXC_PENDING, OVERFLOW;

  always #5 CLK = ~CLK;

  cop_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .I_VALID(I_VALID), .I_READY(I_READY), .I_PC(I_PC),
    .I_REG_W_EN(I_REG_W_EN), .I_REG_W_RD(I_REG_W_RD), .I_REG_W_DATA(I_REG_W_DATA),
    .I_EXC_EN(I_EXC_EN), .I_EXC_CODE(I_EXC_CODE),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_PC(O_PC),
    .O_REG_W_EN(O_REG_W_EN), .O_REG_W_RD(O_REG_W_RD), .O_REG_W_DATA(O_REG_W_DATA),
    .O_EXC_EN(O_EXC_EN), .O_EXC_CODE(O_EXC_CODE),
    .H_RS1(H_RS1), .H_RS2(H_RS2), .H_STALL(H_STALL),
    .COUNT(COUNT), .EXC_PENDING(EXC_PENDING), .OVERFLOW(OVERFLOW)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [3:0]  code;
  } ent_t;

  ent_t sb[$];
  bit   m_exc = 1'b0;
  bit   m_ovf = 1'b0;
  bit   in_wen = 1'b1;
  int   pc_n = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check pre-edge outputs against the model, then advance.
  task automatic cyc(input bit v, input logic [4:0] rd, input logic [31:0] data,
                     input bit exc, input logic [3:0] code, input bit ordy, input bit fl);
    ent_t e;
    bit   st;
    bit   full;
    bit   do_push;
    bit   do_pop;
    I_VALID      = v;
    I_PC         = 32'h1000 + 32'(pc_n * 4);
    I_REG_W_EN   = in_wen;
    I_REG_W_RD   = rd;
    I_REG_W_DATA = data;
    I_EXC_EN     = exc;
    I_EXC_CODE   = code;
    O_READY      = ordy;
    FLUSH        = fl;
    pc_n++;
    #1;
    st = 1'b0;
    foreach (sb[i])
      if (sb[i].wen && ((H_RS1 != 5'd0 && sb[i].rd == H_RS1) || (H_RS2 != 5'd0 && sb[i].rd == H_RS2)))
        st = 1'b1;
    chk("count", 32'(COUNT), 32'(sb.size()));
    chk("i_ready", 32'(I_READY), 32'(sb.size() != DEPTH));
    chk("o_valid", 32'(O_VALID), 32'(sb.size() != 0));
    chk("exc_pending", 32'(EXC_PENDING), 32'(m_exc));
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
    chk("h_stall", 32'(H_STALL), 32'(st));
    if (sb.size() == 0) begin
      chk("o_zero_when_empty", O_PC | O_REG_W_DATA | 32'({O_REG_W_EN, O_REG_W_RD, O_EXC_EN, O_EXC_CODE}), 32'd0);
    end else begin
      chk("o_pc", O_PC, sb[0].pc);
      chk("o_wen", 32'(O_REG_W_EN), 32'(sb[0].wen));
      chk("o_rd", 32'(O_REG_W_RD), 32'(sb[0].rd));
      chk("o_data", O_REG_W_DATA, sb[0].data);
      chk("o_exc", 32'(O_EXC_EN), 32'(sb[0].exc));
      chk("o_code", 32'(O_EXC_CODE), 32'(sb[0].code));
    end
    if (!RST) begin
      sb.delete();
      m_exc = 1'b0;
      m_ovf = 1'b0;
    end else begin
      full    = (sb.size() == DEPTH);
      do_push = v && !full && !m_exc && !fl;
      do_pop  = (sb.size() != 0) && ordy && !fl;
      if (v && full && !m_exc) m_ovf = 1'b1;
      if (fl) begin
        sb.delete();
        m_exc = 1'b0;
      end else begin
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
          e = '{pc: I_PC, wen: in_wen && (rd != 5'd0), rd: rd, data: data, exc: exc, code: code};
          sb.push_back(e);
          if (exc) m_exc = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; FLUSH = 1'b0; I_VALID = 1'b0; O_READY = 1'b0;
    I_PC = '0; I_REG_W_EN = 1'b0; I_REG_W_RD = '0; I_REG_W_DATA = '0;
    I_EXC_EN = 1'b0; I_EXC_CODE = '0; H_RS1 = '0; H_RS2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // In-order fill and drain
    cyc(1, 1, 32'h11, 0, 0, 0, 0);
    cyc(1, 2, 32'h22, 0, 0, 0, 0);
    cyc(1, 3, 32'h33, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Full queue, overflow, then pointer wrap under push+pop
    for (int i = 0; i < 4; i++) cyc(1, 5'(4 + i), 32'hA0 + 32'(i), 0, 0, 0, 0);
    cyc(1, 9, 32'hBB, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 5'(10 + i), 32'hC0 + 32'(i), 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 1, 0);

    // Hazard detection
    H_RS1 = 5'd5;
    cyc(1, 5, 32'h55, 0, 0, 0, 0);
    cyc(1, 0, 32'h66, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    H_RS1 = 5'd0;

    // Exception block, drain, flush, resume
    cyc(1, 8, 32'h77, 1, 4'h2, 0, 0);
    cyc(1, 9, 32'h78, 0, 0, 0, 0);
    cyc(1, 10, 32'h79, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 11, 32'h88, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Flush beats simultaneous push and pop
    cyc(1, 12, 32'h91, 0, 0, 0, 0);
    cyc(1, 13, 32'h92, 0, 0, 0, 0);
    cyc(1, 14, 32'h93, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Mid-stream reset with entries queued and overflow set
    for (int i = 0; i < 3; i++) cyc(1, 5'(16 + i), 32'hD0 + 32'(i), 0, 0, 0, 0);
    RST = 1'b0;
    cyc(1, 20, 32'hEE, 0, 0, 1, 0);
    RST = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Random traffic with hazard probes on both source ports
    for (int i = 0; i < 60; i++) begin
      H_RS1  = 5'($urandom_range(0, 7));
      H_RS2  = 5'($urandom_range(0, 7));
      in_wen = 1'($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0 && i > 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cop_wb_queue.md
# cop_wb_queue

Result writeback queue between a coprocessor Exec stage and the core's register-file write port. It captures each valid Exec-stage result (register write and/or exception), buffers up to DEPTH entries in order, and drains them to the core under a valid/ready handshake. It also reports read-after-write hazards against queued destination registers so the core's Ready stage can stall, and it blocks further results after an exception until flushed.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- AW, 2, pointer width; equals log2(DEPTH)

- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-low
- FLUSH  in  1  discard all entries and clear exception block
- I_VALID  in  1  Exec result valid (driven by coprocessor E_VALID)
- I_READY  out  1  queue can accept; equals not full
- I_PC  in  32  PC of the instruction
- I_REG_W_EN  in  1  result writes a register
- I_REG_W_RD  in  5  destination register
- I_REG_W_DATA  in  32  write data
- I_EXC_EN  in  1  instruction raised an exception
- I_EXC_CODE  in  4  exception cause
- O_VALID  out  1  head entry present
- O_READY  in  1  core consumes head this cycle
- O_PC, O_REG_W_EN, O_REG_W_RD, O_REG_W_DATA, O_EXC_EN, O_EXC_CODE  out  32/1/5/32/1/4  head entry fields
- H_RS1, H_RS2  in  5 each  source registers of instruction in Ready stage
- H_STALL  out  1  a queued entry writes H_RS1 or H_RS2
- COUNT  out  AW+1  number of queued entries
- EXC_PENDING  out  1  exception entry accepted, block active
- OVERFLOW  out  1  sticky: I_VALID seen while I_READY low

## Operation
- Storage: DEPTH-entry register array, write pointer, read pointer (AW bits, wrap modulo DEPTH), COUNT register.
- Push: I_VALID && I_READY && !EXC_PENDING && !FLUSH. Stored REG_W_EN = I_REG_W_EN && (I_REG_W_RD != 0); x0 writes are stored as non-writing entries.
- Pop: O_VALID && O_READY && !FLUSH. Push and pop in the same cycle: COUNT unchanged, both pointers advance.
- I_READY = (COUNT != DEPTH). Full queue: push not performed, OVERFLOW set, held until reset. Simultaneous pop does not create room for a push in that cycle.
- Empty: O_VALID = 0 and all O_* fields driven 0. Non-empty: O_* combinationally reflect the head entry.
- Exception block: on push of an entry with I_EXC_EN = 1, EXC_PENDING sets next cycle. While set, I_VALID is ignored: no push, no OVERFLOW. The exception entry and earlier entries still drain normally. FLUSH clears EXC_PENDING.
- Hazard: H_STALL = 1 if any valid entry has REG_W_EN = 1 and RD equal to a nonzero H_RS1 or H_RS2. An entry being pushed in the current cycle is not included. An entry being popped in the current cycle is still included.
- FLUSH: takes priority over push and pop. Next cycle: COUNT = 0, pointers = 0, EXC_PENDING = 0. OVERFLOW is unaffected.

## Timing
- Reset (RST low at edge): COUNT = 0, pointers = 0, EXC_PENDING = 0, OVERFLOW = 0. Hence O_VALID = 0, O_* = 0, I_READY = 1, H_STALL = 0. Array contents are don't-care.
- RST low overrides FLUSH, push and pop in the same cycle; mid-stream reset loses all entries.
- Enqueue latency: 1 cycle. A result pushed at edge n appears on O_* (if queue was empty) and affects H_STALL after edge n.
- Dequeue: combinational on O_READY; the next entry is visible after the same edge.
- Sustained throughput: one push and one pop per cycle when COUNT is between 1 and DEPTH-1.
- COUNT, I_READY and EXC_PENDING are registered or derived from registers only; there is no combinational path from I_VALID or O_READY to I_READY.

## Test plan
- Reset, then push 3 entries (rd = 1, 2, 3; data = 0x11, 0x22, 0x33) with O_READY = 0 -> COUNT = 3 and O_RD = 1. Then O_READY = 1 for 3 cycles -> pops occur in order 0x11, 0x22, 0x33, followed by O_VALID = 0 with O_* = 0.
- Fill 4 entries with O_READY = 0 -> I_READY = 0. A 5th I_VALID -> not stored, OVERFLOW = 1. Pointers then wrap across 6 further push/pop cycles with data preserved.
- Queue an entry with rd = 5 and set H_RS1 = 5 -> H_STALL = 1. H_RS2 = 0 with a rd = 0 entry -> H_STALL = 0. After rd = 5 entry pops -> H_STALL = 0 next cycle.
- Push an entry with I_EXC_EN = 1 and code 0x2, then 2 more I_VALID -> only the exception entry is queued and EXC_PENDING = 1. Drain -> O_EXC_CODE = 2. FLUSH -> EXC_PENDING = 0 and the next push is accepted.
- With COUNT = 2, assert FLUSH together with I_VALID and O_READY -> COUNT = 0 next cycle, no entry written or consumed.
- Mid-stream RST low for 1 cycle with COUNT = 3 and OVERFLOW = 1 -> all outputs return to their reset values on the next cycle.
